dram_sequencer: RTL
===================

DRAM_SEQUENCER -- requirements
Module: dram_sequencer

Interface
REQ-001 Reset is synchronous and active-high; the design uses one clock, and the clock and reset ports are named clk and rst.
REQ-002 clk  in  1  master clock, the same clock that drives the CPU timing generator; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 T  in  4  timing slot from the CPU timing generator (changes on negedge clk); phase p = T[2:0].
REQ-005 Z_Source  in  1  address owner: 1 = video, 0 = CPU; sampled at p==0.
REQ-006 isRAM  in  1  CPU address decodes to RAM; sampled at p==0.
REQ-007 rw  in  1  CPU read (1) / write (0); sampled at p==0.
REQ-008 cpu_addr  in  16  CPU address.
REQ-009 vdg_addr  in  16  video fetch address.
REQ-010 ram_size  in  2  size selector: 00 = 4K, 01 = 16K, 1x = 64K.
REQ-011 refresh_req  in  1  one-clock pulse that requests a refresh burst.
REQ-012 Z  out  8  multiplexed DRAM address.
REQ-013 RAS_n, CAS_n, WE_n  out  1 each  active-low DRAM strobes.
REQ-014 refresh_active  out  1  high while the current half-slot is a refresh cycle.

Function
REQ-015 All outputs shall be registered and shall be updated on posedge clk from the T value sampled at that edge.
REQ-016 Each half-slot (p = 0..7) shall run exactly one cycle type, chosen at p==0:
- REFRESH if pending>0 and Z_Source=1.
- VIDEO if Z_Source=1 and pending=0.
- CPU if Z_Source=0 and isRAM=1.
- IDLE otherwise.
REQ-017 State machine: IDLE -> ROW (p0) -> RASLOW (p1) -> COL (p2) -> CASLOW (p3..p5) -> PRECHG (p6,p7) -> next decision at p0.
REQ-018 ROW and RAS phases:
- p0: Z = row address.
- p1..p5: RAS_n = 0.
- p2: Z = column address.
REQ-019 CAS_n shall be 0 for p3..p5 in VIDEO and CPU cycles only; CAS_n shall stay 1 in REFRESH cycles (RAS-only refresh).
REQ-020 WE_n shall be 0 for p3..p5 only in CPU cycles with rw=0; in every other case WE_n shall be 1.
REQ-021 p6 and p7: RAS_n = CAS_n = WE_n = 1.
REQ-022 IDLE: all strobes shall stay 1 and Z shall hold its last value.
REQ-023 Address split by ram_size; Z bits above the used width are 0:
- 4K: row A[5:0], column A[11:6].
- 16K: row A[6:0], column A[13:7].
- 64K: row A[7:0], column A[15:8].
REQ-024 REFRESH: Z = refresh_row[7:0]; refresh_row shall increment by 1 at p7 of each refresh cycle and wrap from 255 to 0.
REQ-025 pending (4-bit) handling:
- refresh_req shall add 8, saturating at 15.
- Each completed refresh cycle (p7) shall subtract 1.
- refresh_req and a completion in the same clock shall give a net +7, saturating at 15.
REQ-026 In fast mode Z_Source=0 at both p0 decisions, so both halves of T shall run CPU cycles.
REQ-027 If T jumps to a phase other than p+1, the sequencer shall abort to PRECHG with all strobes high and resume at the next p0.

Reset
REQ-028 On rst:
- RAS_n = CAS_n = WE_n = 1, Z = 0, refresh_active = 0.
- pending = 0, refresh_row = 0, state = IDLE.
REQ-029 Reset mid-cycle shall deassert all strobes at the next edge; no partial cycle shall resume; the first cycle after reset starts at the next p0 with rst low.

Structure
REQ-030 The shared package shall hold:
- phase constants P_ROW..P_PRE;
- ram_size encodings;
- the cycle-type enum (IDLE, VIDEO, CPU, REFRESH);
- REFRESH_BURST = 8 and PENDING_MAX = 15.
REQ-031 The combinational row/column split shall be in one sub-module, dram_addr_mux (inputs addr and ram_size; outputs row and col).

Verification
REQ-032 64K, Z_Source=0, isRAM=1, rw=1, cpu_addr=0xA55A:
- p0: Z = 0x5A; p2: Z = 0xA5.
- RAS_n low p1..p5; CAS_n low p3..p5; WE_n = 1 throughout.
REQ-033 16K, CPU write, rw=0, cpu_addr=0x3FFF:
- row = 0x7F, col = 0x7F.
- WE_n low exactly at p3..p5.
REQ-034 One refresh_req pulse with Z_Source=1:
- the next 8 video half-slots are RAS-only refresh, with CAS_n = 1 and Z = 0..7;
- the 9th is a normal VIDEO cycle.
REQ-035 refresh_req pulsed 3 times in 2 clocks: pending = 15, not 24; refresh_row wraps 255 -> 0 when preloaded with 255.
REQ-036 isRAM=0 CPU slot: no strobe activity. rst asserted at p4: all strobes are 1 at the next edge and stay 1 until the first p0 after reset.

Source files
------------

// File: rtl/dram_sequencer_pkg.sv
// Shared constants and types for the DRAM sequencer: phase numbers, size codes,
// cycle types and refresh bookkeeping limits.
package dram_sequencer_pkg;

  localparam logic [2:0] P_ROW     = 3'd0;
  localparam logic [2:0] P_RAS     = 3'd1;
  localparam logic [2:0] P_COL     = 3'd2;
  localparam logic [2:0] P_CAS     = 3'd3;
  localparam logic [2:0] P_CAS_END = 3'd5;
  localparam logic [2:0] P_PRE     = 3'd6;
  localparam logic [2:0] P_LAST    = 3'd7;

  localparam logic [1:0] RS_4K  = 2'b00;
  localparam logic [1:0] RS_16K = 2'b01;
  localparam logic [1:0] RS_64K = 2'b10;

  typedef enum logic [1:0] {CYC_IDLE, CYC_VIDEO, CYC_CPU, CYC_REFRESH} cyc_t;

  localparam logic [3:0] REFRESH_BURST = 4'd8;
  localparam logic [3:0] PENDING_MAX   = 4'd15;

  // A request and a completion in the same clock net to +7; done implies cur >= 1.
  function automatic logic [3:0] pending_next(input logic [3:0] cur,
                                              input logic req, input logic done);
    logic [4:0] sum;
    sum = {1'b0, cur} + (req ? {1'b0, REFRESH_BURST} : 5'd0) - (done ? 5'd1 : 5'd0);
    return (sum > {1'b0, PENDING_MAX}) ? PENDING_MAX : sum[3:0];
  endfunction

endpackage

// File: rtl/dram_addr_mux.sv
// Row/column split of a 16-bit address for the selected DRAM size; unused high bits are 0.
module dram_addr_mux import dram_sequencer_pkg::*; (
  input  logic [15:0] addr,
  input  logic [1:0]  ram_size,
  output logic [7:0]  row,
  output logic [7:0]  col
);
  always_comb begin
    row = '0;
    col = '0;
    case (ram_size)
      RS_4K: begin
        row = {2'b00, addr[5:0]};
        col = {2'b00, addr[11:6]};
      end
      RS_16K: begin
        row = {1'b0, addr[6:0]};
        col = {1'b0, addr[13:7]};
      end
      default: begin
        row = addr[7:0];
        col = addr[15:8];
      end
    endcase
  end
endmodule

// File: rtl/dram_sequencer.sv
// Per-half-slot DRAM cycle sequencer driven by the CPU timing phase: picks
// refresh/video/CPU/idle at p0 and generates the registered address and strobes.
module dram_sequencer import dram_sequencer_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  T,
  input  logic        Z_Source,
  input  logic        isRAM,
  input  logic        rw,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] vdg_addr,
  input  logic [1:0]  ram_size,
  input  logic        refresh_req,
  output logic [7:0]  Z,
  output logic        RAS_n,
  output logic        CAS_n,
  output logic        WE_n,
  output logic        refresh_active
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ROW    = 3'd1;
  localparam logic [2:0] ST_RASLOW = 3'd2;
  localparam logic [2:0] ST_COL    = 3'd3;
  localparam logic [2:0] ST_CASLOW = 3'd4;
  localparam logic [2:0] ST_PRECHG = 3'd5;

  logic [2:0]  p, prev_p, st;
  cyc_t        cyc, dec;
  logic [3:0]  pending;
  logic [7:0]  refresh_row, row, col;
  logic        is_write, in_seq, done, use_vdg;
  logic [15:0] mux_addr;

  assign p        = T[2:0];
  assign in_seq   = (p == prev_p + 3'd1);
  // Only a refresh that ran its full sequence to p7 counts; aborts clear cyc.
  assign done     = (p == P_LAST) && in_seq && (st == ST_PRECHG) && (cyc == CYC_REFRESH);
  assign use_vdg  = (p == P_ROW) ? Z_Source : (cyc == CYC_VIDEO);
  assign mux_addr = use_vdg ? vdg_addr : cpu_addr;

  always_comb begin
    dec = CYC_IDLE;
    if (Z_Source) dec = (pending != 4'd0) ? CYC_REFRESH : CYC_VIDEO;
    else if (isRAM) dec = CYC_CPU;
  end

  dram_addr_mux u_addr_mux (
    .addr     (mux_addr),
    .ram_size (ram_size),
    .row      (row),
    .col      (col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Z              <= '0;
      RAS_n          <= 1'b1;
      CAS_n          <= 1'b1;
      WE_n           <= 1'b1;
      refresh_active <= 1'b0;
      pending        <= '0;
      refresh_row    <= '0;
      st             <= ST_IDLE;
      cyc            <= CYC_IDLE;
      is_write       <= 1'b0;
      prev_p         <= '0;
    end else begin
      prev_p  <= p;
      pending <= pending_next(pending, refresh_req, done);
      RAS_n   <= 1'b1;
      CAS_n   <= 1'b1;
      WE_n    <= 1'b1;
      if (done) refresh_row <= refresh_row + 8'd1;

      if (p == P_ROW) begin
        cyc            <= dec;
        is_write       <= ~rw;
        refresh_active <= (dec == CYC_REFRESH);
        st             <= (dec == CYC_IDLE) ? ST_IDLE : ST_ROW;
        if (dec == CYC_REFRESH) Z <= refresh_row;
        else if (dec != CYC_IDLE) Z <= row;
      end else if (st == ST_IDLE || st == ST_PRECHG) begin
        // strobes stay high until the next p0 decision
      end else if (!in_seq) begin
        st             <= ST_PRECHG;
        cyc            <= CYC_IDLE;
        refresh_active <= 1'b0;
      end else if (p == P_RAS) begin
        st    <= ST_RASLOW;
        RAS_n <= 1'b0;
      end else if (p == P_COL) begin
        st    <= ST_COL;
        RAS_n <= 1'b0;
        if (cyc != CYC_REFRESH) Z <= col;
      end else if (p >= P_CAS && p <= P_CAS_END) begin
        st    <= ST_CASLOW;
        RAS_n <= 1'b0;
        CAS_n <= (cyc == CYC_REFRESH);
        WE_n  <= ~((cyc == CYC_CPU) && is_write);
      end else begin
        st <= ST_PRECHG;
      end
    end
  end
endmodule
